// File: rtl/mii_rx_byte_packer.sv
// MII receive front end: strips preamble/SFD, packs nibbles into bytes for the bridge FIFO and reports per-frame status.
// Optional FCS checking is compiled in with `define RX_CRC_CHECK_EN.
module mii_rx_byte_packer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mii_rx_dv,
    input  logic             mii_rx_er,
    input  logic [3:0]       mii_rxd,
    input  logic             fifo_full,
    output logic             fifo_write,
    output logic [7:0]       fifo_data,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err,
    output logic             overflow,
    output logic             crc_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    // Reset asserts immediately but releases only after two rx clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    state_t           state_q;
    logic             phase_q;
    logic [3:0]       low_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             giant_q;
    logic             rxer_q;
    logic             fifo_write_q;
    logic [7:0]       fifo_data_q;
    logic             frame_done_q;
    logic [LEN_W-1:0] frame_len_q;
    logic             frame_err_q;
    logic             overflow_q;
    logic             crc_err_q;

    logic             nib_ok;
    logic             crc_bad;
    logic             dribble;
    logic             frame_err_d;

    assign nib_ok = mii_rx_dv && !mii_rx_er;

`ifdef RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q ^ {28'd0, mii_rxd};
        for (int i = 0; i < 4; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)                    crc_q <= CRC_INIT;
        else if (state_q == S_PREAMBLE)    crc_q <= CRC_INIT;
        else if (state_q == S_DATA && nib_ok) crc_q <= crc_d;
    end

    assign crc_bad = (crc_q != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    // A lone low nibble when rx_dv falls is dribble and counts as an error.
    assign dribble     = (state_q == S_DATA) && phase_q;
    assign frame_err_d = (len_q < MIN_LEN_C) | giant_q | rxer_q | overflow_q | dribble | crc_bad;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            low_q        <= 4'h0;
            len_q        <= '0;
            cnt_q        <= '0;
            giant_q      <= 1'b0;
            rxer_q       <= 1'b0;
            fifo_write_q <= 1'b0;
            fifo_data_q  <= 8'h00;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            fifo_write_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mii_rx_dv) begin
                        if (mii_rxd == 4'h5) begin
                            state_q <= S_PREAMBLE;
                        end else begin
                            state_q <= S_DROP;
                            phase_q <= 1'b0;
                            len_q   <= '0;
                            cnt_q   <= '0;
                            giant_q <= 1'b0;
                            rxer_q  <= 1'b0;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!nib_ok) begin
                        state_q <= S_IDLE;
                    end else if (mii_rxd == 4'hD) begin
                        state_q    <= S_DATA;
                        overflow_q <= 1'b0;
                        phase_q    <= 1'b0;
                        len_q      <= '0;
                        cnt_q      <= '0;
                        giant_q    <= 1'b0;
                        rxer_q     <= 1'b0;
                    end else if (mii_rxd != 4'h5) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!mii_rx_dv) begin
                        state_q      <= S_DONE;
                        frame_done_q <= 1'b1;
                        frame_len_q  <= len_q;
                        frame_err_q  <= frame_err_d;
                        crc_err_q    <= crc_bad;
                    end else if (mii_rx_er) begin
                        rxer_q  <= 1'b1;
                        state_q <= S_DROP;
                    end else if (!phase_q) begin
                        low_q   <= mii_rxd;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (cnt_q == MAX_LEN_C) begin
                            giant_q <= 1'b1;
                            state_q <= S_DROP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (fifo_full) begin
                                overflow_q <= 1'b1;
                            end else begin
                                fifo_write_q <= 1'b1;
                                fifo_data_q  <= {mii_rxd, low_q};
                                len_q        <= len_q + 1'b1;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (!mii_rx_dv) begin
                        state_q      <= S_DONE;
                        frame_done_q <= 1'b1;
                        frame_len_q  <= len_q;
                        frame_err_q  <= frame_err_d;
                        crc_err_q    <= crc_bad;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_write = fifo_write_q;
    assign fifo_data  = fifo_data_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign crc_err    = crc_err_q;

endmodule

// File: tb/tb_mii_rx_byte_packer.sv
// Directed bench for mii_rx_byte_packer: legal, overflow, runt, giant, rx_er, dribble, abort and reset cases.
// CRC cases run only when RX_CRC_CHECK_EN is defined.
module tb_mii_rx_byte_packer;

    logic        clk;
    logic        rst_n;
    logic        mii_rx_dv;
    logic        mii_rx_er;
    logic [3:0]  mii_rxd;
    logic        fifo_full;
    logic        fifo_write;
    logic [7:0]  fifo_data;
    logic        frame_done;
    logic [10:0] frame_len;
    logic        frame_err;
    logic        overflow;
    logic        crc_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int first_wr_cyc = -1;
    int drive_cyc = 0;

    logic [7:0] tx_buf[$];
    logic [7:0] exp_q[$];
    logic [7:0] wr_q[$];

    mii_rx_byte_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mii_rx_dv  (mii_rx_dv),
        .mii_rx_er  (mii_rx_er),
        .mii_rxd    (mii_rxd),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .crc_err    (crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fifo_write) begin
            wr_q.push_back(fifo_data);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (frame_done) done_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_nib(input bit dv, input bit er, input logic [3:0] d);
        @(posedge clk);
        #1;
        mii_rx_dv = dv;
        mii_rx_er = er;
        mii_rxd   = d;
    endtask

    task automatic fill(input int n);
        tx_buf.delete();
        for (int i = 0; i < n; i++) tx_buf.push_back(8'(i));
    endtask

    task automatic preamble();
        for (int k = 0; k < 15; k++) send_nib(1'b1, 1'b0, 4'h5);
        send_nib(1'b1, 1'b0, 4'hD);
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Sends tx_buf with fifo_full raised for bytes full_lo..full_hi, rx_er on byte er_at.
    task automatic send_frame(input string tag, input int full_lo, input int full_hi,
                              input int er_at, input bit dribble);
        logic [7:0] b;
        bit         full;
        bit         stop;
        exp_q.delete();
        wr_q.delete();
        done_cnt     = 0;
        first_wr_cyc = -1;
        stop         = 1'b0;
        preamble();
        for (int i = 0; i < tx_buf.size() && !stop; i++) begin
            b = tx_buf[i];
            if (i == er_at) begin
                send_nib(1'b1, 1'b1, b[3:0]);
                send_nib(1'b1, 1'b0, b[7:4]);
                send_nib(1'b1, 1'b0, 4'h0);
                stop = 1'b1;
            end else begin
                full = (i >= full_lo) && (i <= full_hi);
                send_nib(1'b1, 1'b0, b[3:0]);
                fifo_full = full;
                send_nib(1'b1, 1'b0, b[7:4]);
                if (i == 0) drive_cyc = cyc;
                if (!full && i < 1518) exp_q.push_back(b);
            end
        end
        if (dribble) send_nib(1'b1, 1'b0, 4'h3);
        send_nib(1'b0, 1'b0, 4'h0);
        fifo_full = 1'b0;
        wait_done(tag);
    endtask

    task automatic check_frame(input string tag, input int exp_len, input bit exp_err,
                               input bit exp_ovf, input bit exp_crc);
        int mism;
        mism = 0;
        chk({tag, "_len"}, 32'(frame_len), 32'(exp_len));
        chk({tag, "_err"}, 32'(frame_err), 32'(exp_err));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_crc"}, 32'(crc_err), 32'(exp_crc));
        chk({tag, "_n_wr"}, 32'(wr_q.size()), 32'(exp_len));
        chk({tag, "_n_done"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) mism++;
        chk({tag, "_data"}, 32'(mism), 32'd0);
    endtask

`ifdef RX_CRC_CHECK_EN
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        bit          fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ tx_buf[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_crc_frame();
        logic [31:0] f;
        fill(60);
        f = fcs_of(60);
        tx_buf.push_back(f[7:0]);
        tx_buf.push_back(f[15:8]);
        tx_buf.push_back(f[23:16]);
        tx_buf.push_back(f[31:24]);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        mii_rx_dv = 1'b0;
        mii_rx_er = 1'b0;
        mii_rxd   = 4'h0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {13'd0, fifo_write, frame_done, frame_len, frame_err, overflow, crc_err, fifo_data},
            32'd0);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        fill(64);
        send_frame("legal64", -1, -1, -1, 1'b0);
        check_frame("legal64", 64, 1'b0, 1'b0, 1'b0);
        chk("write_latency", 32'(first_wr_cyc - drive_cyc), 32'd1);

        send_frame("full10_12", 10, 12, -1, 1'b0);
        check_frame("full10_12", 61, 1'b1, 1'b1, 1'b0);

        fill(40);
        send_frame("runt40", -1, -1, -1, 1'b0);
        check_frame("runt40", 40, 1'b1, 1'b0, 1'b0);

        fill(63);
        send_frame("runt63", -1, -1, -1, 1'b0);
        check_frame("runt63", 63, 1'b1, 1'b0, 1'b0);

        fill(64);
        send_frame("legal_after", -1, -1, -1, 1'b0);
        check_frame("legal_after", 64, 1'b0, 1'b0, 1'b0);

        fill(1518);
        send_frame("max1518", -1, -1, -1, 1'b0);
        check_frame("max1518", 1518, 1'b0, 1'b0, 1'b0);

        fill(1519);
        send_frame("giant1519", -1, -1, -1, 1'b0);
        check_frame("giant1519", 1518, 1'b1, 1'b0, 1'b0);

        fill(64);
        send_frame("rxer20", -1, -1, 19, 1'b0);
        check_frame("rxer20", 19, 1'b1, 1'b0, 1'b0);

        send_frame("dribble", -1, -1, -1, 1'b1);
        check_frame("dribble", 64, 1'b1, 1'b0, 1'b0);

        done_cnt = 0;
        send_nib(1'b1, 1'b0, 4'h5);
        send_nib(1'b1, 1'b0, 4'h5);
        send_nib(1'b1, 1'b0, 4'h7);
        send_nib(1'b0, 1'b0, 4'h0);
        repeat (6) @(negedge clk);
        chk("pre_abort_no_done", 32'(done_cnt), 32'd0);

        // Reset in the middle of a frame; the tail must land in IDLE and be dropped.
        done_cnt = 0;
        preamble();
        for (int i = 0; i < 10; i++) begin
            send_nib(1'b1, 1'b0, 4'(i));
            send_nib(1'b1, 1'b0, 4'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_outputs", {13'd0, fifo_write, frame_done, frame_len, frame_err, overflow, crc_err, fifo_data},
            32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 10; i < 20; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_nib(1'b1, 1'b0, b[3:0]);
            send_nib(1'b1, 1'b0, b[7:4]);
        end
        send_nib(1'b0, 1'b0, 4'h0);
        wait_done("reset_tail");
        chk("reset_tail_len", 32'(frame_len), 32'd0);
        chk("reset_tail_err", 32'(frame_err), 32'd1);
        chk("reset_tail_n_done", 32'(done_cnt), 32'd1);

`ifdef RX_CRC_CHECK_EN
        build_crc_frame();
        send_frame("crc_good", -1, -1, -1, 1'b0);
        check_frame("crc_good", 64, 1'b0, 1'b0, 1'b0);

        build_crc_frame();
        tx_buf[5] = tx_buf[5] ^ 8'h01;
        send_frame("crc_bad", -1, -1, -1, 1'b0);
        check_frame("crc_bad", 64, 1'b1, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
